// File: rtl/pp_accumulator.sv
// rtl/pp_accumulator.sv - exponent-aligned partial-product window accumulator
module pp_accumulator #(
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_W       = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       signed_pp,
  input  logic [4:0]       exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic [7:0]       count
);

  localparam logic [7:0] LAST = 8'(KERNEL_SIZE - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [7:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] pp_ext, term, sum;
  logic             accept;

  assign pp_ext   = {{(ACC_W-5){signed_pp[4]}}, signed_pp};
  assign term     = pp_ext << exp;
  // The first product of a window replaces the accumulator rather than adding to it.
  assign sum      = (count_q == 8'd0) ? term : acc_q + term;
  assign in_ready = (state_q == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign count     = count_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    result_d    = result_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d   = '0;
          count_d = 8'd0;
        end else if (accept) begin
          if (count_q == LAST) begin
            result_d    = sum;
            out_valid_d = 1'b1;
            count_d     = 8'd0;
            state_d     = HOLD;
          end else begin
            acc_d   = sum;
            count_d = count_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      result_q    <= '0;
      count_q     <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pp_accumulator.sv
// tb/tb_pp_accumulator.sv - randomized self-checking bench for pp_accumulator
module tb_pp_accumulator;
  localparam int ACC_W = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, clear, in_valid, out_ready, in_ready, out_valid;
  logic [4:0]       signed_pp, exp;
  logic [ACC_W-1:0] result;
  logic [7:0]       count;

  logic             in_valid1, out_ready1, in_ready1, out_valid1, clear1;
  logic [4:0]       pp1, exp1;
  logic [ACC_W-1:0] result1;
  logic [7:0]       count1;

  int     tests = 0;
  int     fails = 0;
  longint model_sum;

  pp_accumulator #(.KERNEL_SIZE(9), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .signed_pp(signed_pp), .exp(exp), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .count(count)
  );

  pp_accumulator #(.KERNEL_SIZE(1), .ACC_W(ACC_W)) dut_k1 (
    .clk(clk), .rst(rst), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
    .signed_pp(pp1), .exp(exp1), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .count(count1)
  );

  function automatic longint term_of(input logic [4:0] pp, input logic [4:0] e);
    return longint'($signed(pp)) * (longint'(1) << e);
  endfunction

  task automatic send(input logic [4:0] pp, input logic [4:0] e);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; signed_pp = pp; exp = e;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end else begin
      model_sum += term_of(pp, e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; signed_pp = 'x; exp = 'x;
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_during got %0b want 0", in_ready); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (result !== '0) begin fails++; $display("FAIL reset_result got %0h want 0", result); end
    tests++; if (count !== 8'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_ones();
    model_sum = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(5'd1, 5'd0);
      if (i < 8) begin
        tests++; if (count !== 8'(i + 1)) begin fails++; $display("FAIL ones_count got %0d want %0d", count, i + 1); end
      end
    end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ones_out_valid got %0b want 1", out_valid); end
    tests++; if (result !== 40'd9) begin fails++; $display("FAIL ones_result got %0d want 9", result); end
    tests++; if (count !== 8'd0) begin fails++; $display("FAIL ones_count_wrap got %0d want 0", count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ones_in_ready_hold got %0b want 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ones_pulse got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ones_ready_after got %0b want 1", in_ready); end
  endtask

  task automatic test_extreme();
    logic [39:0] want;
    want = 40'(-64'sd309237645312);
    model_sum = 0;
    for (int i = 0; i < 9; i++) send(5'b10000, 5'd31);
    tests++; if (result !== want) begin fails++; $display("FAIL extreme_result got %0d want %0d", $signed(result), $signed(want)); end
    ack();
  endtask

  task automatic test_mixed();
    model_sum = 0;
    send(5'd3, 5'd2);
    send(5'b11011, 5'd0);
    send(5'd7, 5'd4);
    for (int i = 0; i < 6; i++) send(5'd0, 5'd0);
    tests++; if (result !== 40'd119) begin fails++; $display("FAIL mixed_result got %0d want 119", $signed(result)); end
    ack();
  endtask

  task automatic test_backpressure();
    logic [39:0] want;
    model_sum = 0;
    for (int i = 0; i < 9; i++) send(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    want = model_sum[39:0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; signed_pp = 5'd7; exp = 5'd3;
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
      tests++; if (result !== want || out_valid !== 1'b1) begin fails++; $display("FAIL bp_stable got %0h/%0b want %0h/1", result, out_valid, want); end
      tests++; if (count !== 8'd0) begin fails++; $display("FAIL bp_count got %0d want 0", count); end
    end
    @(negedge clk);
    in_valid = 1'b0; signed_pp = 'x; exp = 'x;
    ack();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got %0b/%0b want 0/1", out_valid, in_ready); end
    model_sum = 0;
    for (int i = 0; i < 9; i++) send(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    want = model_sum[39:0];
    tests++; if (result !== want) begin fails++; $display("FAIL bp_next_result got %0h want %0h", result, want); end
    ack();
  endtask

  task automatic test_bubbles();
    model_sum = 0;
    for (int i = 0; i < 9; i++) begin
      send(5'd2, 5'd1);
      @(negedge clk);
      if (i < 8) begin
        tests++; if (count !== 8'(i + 1)) begin fails++; $display("FAIL bubble_count got %0d want %0d", count, i + 1); end
      end
    end
    tests++; if (result !== 40'd36 || out_valid !== 1'b1) begin fails++; $display("FAIL bubble_result got %0d/%0b want 36/1", result, out_valid); end
    ack();
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 4; i++) send(5'd5, 5'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (count !== 8'd0 || result !== '0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_state got %0d/%0h/%0b want 0/0/0", count, result, out_valid); end
    model_sum = 0;
    for (int i = 0; i < 9; i++) send(5'd1, 5'd0);
    tests++; if (result !== 40'd9) begin fails++; $display("FAIL rst_mid_result got %0d want 9", result); end
    ack();
  endtask

  task automatic test_clear_mid();
    for (int i = 0; i < 4; i++) send(5'd6, 5'd2);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; signed_pp = 5'd5; exp = 5'd1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; signed_pp = 'x; exp = 'x;
    tests++; if (count !== 8'd0) begin fails++; $display("FAIL clear_mid_count got %0d want 0", count); end
    model_sum = 0;
    for (int i = 0; i < 9; i++) send(5'd1, 5'd0);
    tests++; if (result !== 40'd9) begin fails++; $display("FAIL clear_mid_result got %0d want 9", result); end
    ack();
  endtask

  task automatic test_clear_hold();
    model_sum = 0;
    for (int i = 0; i < 9; i++) send(5'd1, 5'd0);
    @(negedge clk);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    tests++; if (out_valid !== 1'b1 || result !== 40'd9) begin fails++; $display("FAIL clear_hold got %0b/%0d want 1/9", out_valid, result); end
    ack();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_hold_ack got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [39:0] want;
    for (int w = 0; w < 6; w++) begin
      model_sum = 0;
      for (int i = 0; i < 9; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      want = model_sum[39:0];
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tests++; if (result !== want || out_valid !== 1'b1) begin fails++; $display("FAIL random_result w%0d got %0h/%0b want %0h/1", w, result, out_valid, want); end
      ack();
    end
  endtask

  task automatic test_k1();
    logic [4:0]  p, e;
    logic [39:0] want;
    longint      t;
    for (int i = 0; i < 4; i++) begin
      p = 5'($urandom_range(0, 31));
      e = 5'($urandom_range(0, 31));
      t = term_of(p, e);
      want = t[39:0];
      @(negedge clk);
      in_valid1 = 1'b1; pp1 = p; exp1 = e;
      tests++; if (in_ready1 !== 1'b1) begin fails++; $display("FAIL k1_ready got %0b want 1", in_ready1); end
      @(posedge clk); #1;
      in_valid1 = 1'b0; pp1 = 'x; exp1 = 'x;
      tests++; if (out_valid1 !== 1'b1 || result1 !== want || count1 !== 8'd0) begin fails++; $display("FAIL k1_result got %0b/%0h/%0d want 1/%0h/0", out_valid1, result1, count1, want); end
      @(negedge clk);
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      tests++; if (out_valid1 !== 1'b0) begin fails++; $display("FAIL k1_ack got %0b want 0", out_valid1); end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    signed_pp = 'x; exp = 'x;
    clear1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; pp1 = 'x; exp1 = 'x;
    test_reset();
    test_ones();
    test_extreme();
    test_mixed();
    test_backpressure();
    test_bubbles();
    test_rst_mid();
    test_clear_mid();
    test_clear_hold();
    test_random();
    test_k1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
